// File: rtl/alu_issue_if.sv
// Command/response handshake bundle between an issuer and alu_issue_ctrl.
interface alu_issue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 5,
   parameter int TAG_WIDTH  = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [OP_WIDTH-1:0]   cmd_op;
   logic [DATA_WIDTH-1:0] cmd_a;
   logic [DATA_WIDTH-1:0] cmd_b;
   logic [TAG_WIDTH-1:0]  cmd_tag;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [3:0]            rsp_flags;
   logic [TAG_WIDTH-1:0]  rsp_tag;
   logic                  rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-command issue controller: latches a command, drives a registered ALU
// for one (integer) or two (FP) cycles, captures the result and holds a response.
module alu_issue_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 5,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_issue_if.slave            bus,
   output logic [DATA_WIDTH-1:0] alu_operand_a,
   output logic [DATA_WIDTH-1:0] alu_operand_b,
   output logic [OP_WIDTH-1:0]   alu_op,
   output logic                  alu_en,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] alu_fp_result,
   input  logic                  alu_zero,
   input  logic                  alu_overflow,
   input  logic                  alu_carry_out,
   input  logic                  alu_negative,
   input  logic                  alu_fp_overflow,
   output logic [15:0]           op_count
);
   typedef enum logic [2:0] {IDLE, EXEC, FP2, CAP, RESP} state_t;

   state_t                state_q, state_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic                  fp_q, fp_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]            rsp_flags_q, rsp_flags_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [15:0]           cnt_q, cnt_d;

   // Opcode holes: 00101, 01010 and everything from 11000 up.
   function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
      return !(op == OP_WIDTH'(5) || op == OP_WIDTH'(10) || op > OP_WIDTH'(23));
   endfunction

   function automatic logic op_is_fp(input logic [OP_WIDTH-1:0] op);
      return (op >= OP_WIDTH'(20)) && (op <= OP_WIDTH'(23));
   endfunction

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      fp_d        = fp_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: if (bus.cmd_valid) begin
            op_d  = bus.cmd_op;
            a_d   = bus.cmd_a;
            b_d   = bus.cmd_b;
            tag_d = bus.cmd_tag;
            fp_d  = op_is_fp(bus.cmd_op);
            if (op_legal(bus.cmd_op)) begin
               state_d = EXEC;
            end else begin
               state_d     = RESP;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
               rsp_flags_d = '0;
            end
         end
         EXEC: state_d = fp_q ? FP2 : CAP;
         FP2:  state_d = CAP;
         CAP: begin
            rsp_data_d  = fp_q ? alu_fp_result : alu_result;
            rsp_flags_d = {alu_negative, alu_carry_out,
                           fp_q ? alu_fp_overflow : alu_overflow, alu_zero};
            rsp_err_d   = 1'b0;
            state_d     = RESP;
         end
         RESP: if (bus.rsp_ready) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         fp_q        <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         fp_q        <= fp_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Response handshake and a new accept can never share an edge: ready is IDLE-only.
   assign bus.cmd_ready = (state_q == IDLE) && !rst;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_tag   = tag_q;
   assign bus.rsp_err   = rsp_err_q;
   assign alu_operand_a = a_q;
   assign alu_operand_b = b_q;
   assign alu_op        = op_q;
   assign alu_en        = (state_q == EXEC) || (state_q == FP2);
   assign op_count      = cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small registered ALU model.
module tb_alu_issue_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_if #(.DATA_WIDTH(32), .OP_WIDTH(5), .TAG_WIDTH(4)) bus();

   logic [31:0] alu_operand_a, alu_operand_b, alu_result, alu_fp_result;
   logic [4:0]  alu_op;
   logic        alu_en, alu_zero, alu_overflow, alu_carry_out, alu_negative, alu_fp_overflow;
   logic [15:0] op_count;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_op(alu_op), .alu_en(alu_en),
      .alu_result(alu_result), .alu_fp_result(alu_fp_result),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
      .alu_negative(alu_negative), .alu_fp_overflow(alu_fp_overflow),
      .op_count(op_count)
   );

   // ALU model: registers on alu_en, holds otherwise. FP path only knows 1.0+1.0.
   logic [32:0] r;
   logic        ovf;
   always_comb begin
      r   = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      ovf = (alu_operand_a[31] == alu_operand_b[31]) && (r[31] != alu_operand_a[31]);
      if (alu_op == 5'd1) begin
         r   = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
         ovf = (alu_operand_a[31] != alu_operand_b[31]) && (r[31] != alu_operand_a[31]);
      end
   end
   always @(posedge clk) begin
      if (rst) begin
         alu_result <= '0; alu_fp_result <= '0; alu_zero <= 1'b0; alu_overflow <= 1'b0;
         alu_carry_out <= 1'b0; alu_negative <= 1'b0; alu_fp_overflow <= 1'b0;
      end else if (alu_en) begin
         alu_result      <= r[31:0];
         alu_carry_out   <= r[32];
         alu_zero        <= (r[31:0] == 32'd0);
         alu_negative    <= r[31];
         alu_overflow    <= ovf;
         alu_fp_result   <= (alu_operand_a == 32'h3F80_0000 && alu_operand_b == 32'h3F80_0000)
                            ? 32'h4000_0000 : 32'd0;
         alu_fp_overflow <= 1'b0;
      end
   end

   int en_cnt = 0;
   logic [4:0] en_op;
   always @(negedge clk) if (alu_en) begin en_cnt = en_cnt + 1; en_op = alu_op; end

   int checks = 0, errors = 0, lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Call at posedge+1. lat counts cycles from the accept cycle to first rsp_valid cycle.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
      en_cnt = 0;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
      bus.cmd_tag = '0; bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_alu_en",    32'(alu_en),        32'd0);
      chk("rst_op_count",  32'(op_count),      32'd0);
      chk("rst_alu_op",    32'(alu_op),        32'd0);
      chk("rst_rsp_data",  bus.rsp_data,       32'd0);
      rst = 1'b0;
      #1;
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // ADD 5+7
      issue(5'd0, 32'd5, 32'd7, 4'd3);
      chk("add_lat",   32'(lat),           32'd3);
      chk("add_en",    32'(en_cnt),        32'd1);
      chk("add_op",    32'(en_op),         32'd0);
      chk("add_data",  bus.rsp_data,       32'd12);
      chk("add_flags", 32'(bus.rsp_flags), 32'h0);
      chk("add_tag",   32'(bus.rsp_tag),   32'd3);
      chk("add_err",   32'(bus.rsp_err),   32'd0);
      handshake();
      chk("add_cnt",   32'(op_count),      32'd1);

      // SUB 5-5 sets zero only
      issue(5'd1, 32'd5, 32'd5, 4'd1);
      chk("sub_data",  bus.rsp_data,       32'd0);
      chk("sub_flags", 32'(bus.rsp_flags), 32'h1);
      chk("sub_err",   32'(bus.rsp_err),   32'd0);
      handshake();
      chk("sub_cnt",   32'(op_count),      32'd2);

      // FADD 1.0+1.0: integer path would give 7F000000
      issue(5'd20, 32'h3F80_0000, 32'h3F80_0000, 4'd2);
      chk("fadd_lat",  32'(lat),           32'd4);
      chk("fadd_en",   32'(en_cnt),        32'd2);
      chk("fadd_data", bus.rsp_data,       32'h4000_0000);
      chk("fadd_flags",32'(bus.rsp_flags), 32'h0);
      handshake();
      chk("fadd_cnt",  32'(op_count),      32'd3);

      // Illegal opcode
      issue(5'd31, 32'd4, 32'd4, 4'd9);
      chk("ill_lat",   32'(lat),           32'd1);
      chk("ill_en",    32'(en_cnt),        32'd0);
      chk("ill_err",   32'(bus.rsp_err),   32'd1);
      chk("ill_data",  bus.rsp_data,       32'd0);
      chk("ill_flags", 32'(bus.rsp_flags), 32'h0);
      chk("ill_tag",   32'(bus.rsp_tag),   32'd9);
      handshake();
      chk("ill_cnt",   32'(op_count),      32'd4);

      // Backpressure with a competing command waiting
      issue(5'd0, 32'd100, 32'd23, 4'd6);
      bus.cmd_valid = 1'b1; bus.cmd_op = 5'd0; bus.cmd_a = 32'd1; bus.cmd_b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_data",  bus.rsp_data,       32'd123);
         chk("bp_tag",   32'(bus.rsp_tag),   32'd6);
         chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("bp_cnt",      32'(op_count),      32'd5);
      chk("bp_idle",     32'(bus.cmd_ready), 32'd1);
      chk("bp_no_accept",32'(alu_en),        32'd0);
      chk("bp_rsp_done", 32'(bus.rsp_valid), 32'd0);
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;

      // Reset while in FP2
      bus.cmd_valid = 1'b1; bus.cmd_op = 5'd20;
      bus.cmd_a = 32'h3F80_0000; bus.cmd_b = 32'h3F80_0000; bus.cmd_tag = 4'd5;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("fp2_en", 32'(alu_en), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rstfp_en",    32'(alu_en),        32'd0);
      chk("rstfp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstfp_cnt",   32'(op_count),      32'd0);
      chk("rstfp_idle",  32'(bus.cmd_ready), 32'd1);
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid || alu_en) lat++;
      end
      chk("rstfp_quiet", 32'(lat), 32'd0);
      issue(5'd0, 32'd1, 32'd1, 4'd7);
      chk("post_lat",  32'(lat),     32'd3);
      chk("post_data", bus.rsp_data, 32'd2);
      handshake();
      chk("post_cnt",  32'(op_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
